// File: rtl/sdm_pkg.sv
// Shared definitions for the SDM ratio decoder slice.
// Holds the measurement FSM state type, the datapath widths and a helper
// that clamps the requested window exponent.
package sdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } sdm_state_e;

    localparam int FRAC_W  = 16;   // fractional bits of the Q6.16 ratio
    localparam int DIV_W   = 6;    // width of the instantaneous division word
    localparam int RATIO_W = 22;   // DIV_W + FRAC_W

    // Divider word the loop divider comes out of reset with.
    localparam logic [DIV_W-1:0] DIV_RST = 6'd30;

    // Effective window exponent: requests above wmax are clamped.
    function automatic logic [4:0] clamp_win(input logic [4:0] w, input int wmax);
        return (int'(w) > wmax) ? 5'(wmax) : w;
    endfunction

endpackage

// File: rtl/sdm_win_accum.sv
// Window accumulator for the SDM ratio decoder.
// Sums div_ctrl over the window and tracks its minimum and maximum.
// Ports:
//   div_clk_out, rstn_clkin_s : clock and async active-low reset
//   clear_i                   : start a new window (acc=0, min=63, max=0, count=0)
//   enable_i                  : take the current div_ctrl_i as a sample
//   w_eff_i                   : window exponent in force for this measurement
//   div_ctrl_i                : instantaneous division word
//   sum_o, min_o, max_o       : running results *including* the current input,
//                               so the owner can capture them on the final sample edge
//   last_o                    : the current sample is the 2^w_eff_i-th one
module sdm_win_accum
    import sdm_pkg::*;
(
    input  logic               div_clk_out,
    input  logic               rstn_clkin_s,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [4:0]         w_eff_i,
    input  logic [DIV_W-1:0]   div_ctrl_i,
    output logic [RATIO_W-1:0] sum_o,
    output logic [DIV_W-1:0]   min_o,
    output logic [DIV_W-1:0]   max_o,
    output logic               last_o
);

    logic [RATIO_W-1:0] acc_q;
    logic [DIV_W-1:0]   min_q;
    logic [DIV_W-1:0]   max_q;
    logic [FRAC_W-1:0]  cnt_q;
    logic [FRAC_W:0]    win_len;

    // 63 * 2^16 still fits in 22 bits, so the sum never wraps.
    assign sum_o   = acc_q + RATIO_W'(div_ctrl_i);
    assign min_o   = (div_ctrl_i < min_q) ? div_ctrl_i : min_q;
    assign max_o   = (div_ctrl_i > max_q) ? div_ctrl_i : max_q;
    assign win_len = (FRAC_W+1)'(1) << w_eff_i;
    assign last_o  = ({1'b0, cnt_q} == (win_len - 1'b1));

    always_ff @(posedge div_clk_out or negedge rstn_clkin_s) begin
        if (!rstn_clkin_s) begin
            acc_q <= '0;
            min_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
            min_q <= '1;
            max_q <= '0;
            cnt_q <= '0;
        end else if (enable_i) begin
            acc_q <= sum_o;
            min_q <= min_o;
            max_q <= max_o;
            // Wraps after the final sample of a 2^16 window; the FSM has left ACCUM by then.
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sdm_ratio_decoder.sv
// Receive-side checker for the SDM-driven loop divider.
// Averages div_ctrl over a 2^W window (after a settle period) and reports the
// effective ratio in Q6.16 plus the min/max excursion of the word.
// Ports:
//   div_clk_out, rstn_clkin_s : divided clock and async active-low reset
//   div_ctrl                  : instantaneous division word
//   start, abort              : begin / cancel a measurement (abort wins)
//   win_log2                  : requested window exponent, sampled at start
//   result_ack                : consumer acknowledge of a result
//   busy                      : measurement in progress (SETTLE or ACCUM)
//   result_valid              : result held for the consumer (DONE)
//   ratio_q, ctrl_min, ctrl_max : result of the last completed window
module sdm_ratio_decoder
    import sdm_pkg::*;
#(
    parameter int SETTLE_CYC = 8,
    parameter int WIN_MAX    = 16
) (
    input  logic               div_clk_out,
    input  logic               rstn_clkin_s,
    input  logic [DIV_W-1:0]   div_ctrl,
    input  logic               start,
    input  logic               abort,
    input  logic [4:0]         win_log2,
    input  logic               result_ack,
    output logic               busy,
    output logic               result_valid,
    output logic [RATIO_W-1:0] ratio_q,
    output logic [DIV_W-1:0]   ctrl_min,
    output logic [DIV_W-1:0]   ctrl_max
);

    sdm_state_e         state_q;
    logic [7:0]         settle_cnt_q;
    logic [4:0]         w_eff_q;
    logic               busy_q;
    logic               valid_q;
    logic [RATIO_W-1:0] ratio_out_q;
    logic [DIV_W-1:0]   min_out_q;
    logic [DIV_W-1:0]   max_out_q;

    logic               start_take;
    logic               accum_en;
    logic [4:0]         w_eff_d;
    logic [RATIO_W-1:0] win_sum;
    logic [DIV_W-1:0]   win_min;
    logic [DIV_W-1:0]   win_max;
    logic               win_last;
    logic [RATIO_W-1:0] ratio_d;

    // A start is honoured from IDLE, or from DONE when it arrives with the ack
    // (back-to-back measurement). Abort always suppresses it.
    assign start_take = start && !abort &&
                        ((state_q == IDLE) || ((state_q == DONE) && result_ack));
    assign accum_en   = (state_q == ACCUM) && !abort;
    assign w_eff_d    = clamp_win(win_log2, WIN_MAX);
    // sum / 2^W scaled to Q6.16 is an exact left shift since W <= 16.
    assign ratio_d    = win_sum << (5'(FRAC_W) - w_eff_q);

    sdm_win_accum u_win_accum (
        .div_clk_out  (div_clk_out),
        .rstn_clkin_s (rstn_clkin_s),
        .clear_i      (start_take),
        .enable_i     (accum_en),
        .w_eff_i      (w_eff_q),
        .div_ctrl_i   (div_ctrl),
        .sum_o        (win_sum),
        .min_o        (win_min),
        .max_o        (win_max),
        .last_o       (win_last)
    );

    always_ff @(posedge div_clk_out or negedge rstn_clkin_s) begin
        if (!rstn_clkin_s) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            w_eff_q      <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            ratio_out_q  <= '0;
            min_out_q    <= '0;
            max_out_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_take) begin
                        state_q      <= SETTLE;
                        busy_q       <= 1'b1;
                        settle_cnt_q <= '0;
                        w_eff_q      <= w_eff_d;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (settle_cnt_q == 8'(SETTLE_CYC - 1)) begin
                        state_q <= ACCUM;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (win_last) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        ratio_out_q <= ratio_d;
                        min_out_q   <= win_min;
                        max_out_q   <= win_max;
                    end
                end
                DONE: begin
                    // abort here acts as an acknowledge.
                    if (abort || result_ack) begin
                        valid_q <= 1'b0;
                        if (start_take) begin
                            state_q      <= SETTLE;
                            busy_q       <= 1'b1;
                            settle_cnt_q <= '0;
                            w_eff_q      <= w_eff_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign ratio_q      = ratio_out_q;
    assign ctrl_min     = min_out_q;
    assign ctrl_max     = max_out_q;

endmodule

// File: tb/tb_sdm_ratio_decoder.sv
module tb_sdm_ratio_decoder;

    logic        div_clk_out = 1'b0;
    logic        rstn_clkin_s = 1'b0;
    logic [5:0]  div_ctrl = 6'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  win_log2 = 5'd0;
    logic        result_ack = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [21:0] ratio_q;
    logic [5:0]  ctrl_min;
    logic [5:0]  ctrl_max;

    int checks = 0;
    int errors = 0;

    // Expected result of the last completed window (bench model).
    logic [21:0] last_ratio = '0;
    logic [5:0]  last_min = '0;
    logic [5:0]  last_max = '0;

    always #5 div_clk_out = ~div_clk_out;

    sdm_ratio_decoder #(.SETTLE_CYC(8), .WIN_MAX(16)) dut (
        .div_clk_out  (div_clk_out),
        .rstn_clkin_s (rstn_clkin_s),
        .div_ctrl     (div_ctrl),
        .start        (start),
        .abort        (abort),
        .win_log2     (win_log2),
        .result_ack   (result_ack),
        .busy         (busy),
        .result_valid (result_valid),
        .ratio_q      (ratio_q),
        .ctrl_min     (ctrl_min),
        .ctrl_max     (ctrl_max)
    );

    task automatic tick();
        @(posedge div_clk_out);
        #1;
    endtask

    function automatic int gen_sample(input int mode, input int base, input int i);
        int offs[4] = '{-3, 4, 0, -1};
        case (mode)
            0: return base;
            1: return base + (i % 2);
            2: return base + offs[i % 4];
            default: return int'($urandom_range(0, 63));
        endcase
    endfunction

    // Runs one window (optionally issuing the start edge) and checks the
    // latency and result against an arithmetic model of the average.
    task automatic do_measure(input int w, input int mode, input int base, input bit do_start,
                              input string tag);
        int weff = (w > 16) ? 16 : w;
        int n = 1 << weff;
        longint sum = 0;
        int mn = 63;
        int mx = 0;
        int v;
        logic [21:0] e_ratio;
        if (do_start) begin
            win_log2 = 5'(w);
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_after_start: got %b exp 1", tag, busy);
            end
        end
        win_log2 = 5'($urandom_range(0, 31));
        for (int i = 0; i < 8; i++) begin
            div_ctrl = 6'($urandom_range(0, 63));
            tick();
        end
        for (int i = 0; i < n; i++) begin
            v = gen_sample(mode, base, i);
            div_ctrl = 6'(v);
            sum += v;
            if (v < mn) mn = v;
            if (v > mx) mx = v;
            if (i == n - 1) begin
                checks++;
                if (result_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s early_valid: got valid=%b busy=%b exp valid=0 busy=1",
                             tag, result_valid, busy);
                end
            end
            tick();
        end
        e_ratio = 22'((sum << 16) >> weff);
        checks++;
        if (result_valid !== 1'b1 || busy !== 1'b0 || ratio_q !== e_ratio ||
            ctrl_min !== 6'(mn) || ctrl_max !== 6'(mx)) begin
            errors++;
            $display("FAIL %s result: got v=%b b=%b ratio=%h min=%0d max=%0d exp v=1 b=0 ratio=%h min=%0d max=%0d",
                     tag, result_valid, busy, ratio_q, ctrl_min, ctrl_max, e_ratio, mn, mx);
        end
        last_ratio = e_ratio;
        last_min = 6'(mn);
        last_max = 6'(mx);
        $display("measure %s: W=%0d ratio=%h min=%0d max=%0d", tag, w, ratio_q, ctrl_min, ctrl_max);
    endtask

    task automatic do_ack(input string tag);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || ratio_q !== last_ratio ||
            ctrl_min !== last_min || ctrl_max !== last_max) begin
            errors++;
            $display("FAIL %s ack: got v=%b b=%b ratio=%h min=%0d max=%0d exp v=0 b=0 ratio=%h min=%0d max=%0d",
                     tag, result_valid, busy, ratio_q, ctrl_min, ctrl_max, last_ratio, last_min, last_max);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || ratio_q !== 22'd0 ||
            ctrl_min !== 6'd0 || ctrl_max !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: got b=%b v=%b ratio=%h min=%0d max=%0d exp all 0",
                     busy, result_valid, ratio_q, ctrl_min, ctrl_max);
        end
        repeat (3) @(posedge div_clk_out);
        @(negedge div_clk_out);
        rstn_clkin_s = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got b=%b v=%b exp 0 0", busy, result_valid);
        end
        $display("reset: checked");
    endtask

    task automatic test_constant();
        do_measure(4, 0, 30, 1'b1, "const30_w4");
        checks++;
        if (ratio_q !== 22'h1E0000) begin
            errors++;
            $display("FAIL const30_abs: got %h exp 1e0000", ratio_q);
        end
        do_ack("const30_w4");
    endtask

    task automatic test_alternating();
        do_measure(1, 1, 30, 1'b1, "alt30_31_w1");
        checks++;
        if (ratio_q !== 22'h1E8000) begin
            errors++;
            $display("FAIL alt_abs: got %h exp 1e8000", ratio_q);
        end
        do_ack("alt30_31_w1");
    endtask

    task automatic test_mash_hold();
        do_measure(2, 2, 20, 1'b1, "mash20_w2");
        for (int i = 0; i < 10; i++) begin
            div_ctrl = 6'($urandom_range(0, 63));
            start = (i == 3);
            tick();
            start = 1'b0;
            checks++;
            if (result_valid !== 1'b1 || busy !== 1'b0 || ratio_q !== 22'h140000 ||
                ctrl_min !== 6'd17 || ctrl_max !== 6'd24) begin
                errors++;
                $display("FAIL mash_hold cyc%0d: got v=%b b=%b ratio=%h min=%0d max=%0d exp v=1 b=0 ratio=140000 min=17 max=24",
                         i, result_valid, busy, ratio_q, ctrl_min, ctrl_max);
            end
        end
        do_ack("mash20_w2");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int w = int'($urandom_range(0, 6));
            do_measure(w, 3, 0, 1'b1, $sformatf("rand%0d", k));
            do_ack("rand");
        end
        do_measure(0, 0, 45, 1'b1, "w0");
        checks++;
        if (ratio_q !== 22'(45 << 16)) begin
            errors++;
            $display("FAIL w0_abs: got %h exp %h", ratio_q, 22'(45 << 16));
        end
        do_ack("w0");
    endtask

    task automatic test_abort();
        // abort in DONE behaves as ack
        do_measure(3, 3, 0, 1'b1, "pre_abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || ratio_q !== last_ratio) begin
            errors++;
            $display("FAIL abort_in_done: got v=%b b=%b ratio=%h exp v=0 b=0 ratio=%h",
                     result_valid, busy, ratio_q, last_ratio);
        end
        // abort mid-ACCUM
        win_log2 = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8 + 5) begin
            div_ctrl = 6'($urandom_range(0, 63));
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || ratio_q !== last_ratio ||
            ctrl_min !== last_min || ctrl_max !== last_max) begin
            errors++;
            $display("FAIL abort_accum: got b=%b v=%b ratio=%h min=%0d max=%0d exp b=0 v=0 ratio=%h min=%0d max=%0d",
                     busy, result_valid, ratio_q, ctrl_min, ctrl_max, last_ratio, last_min, last_max);
        end
        repeat (20) tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_hold: got v=%b b=%b exp 0 0", result_valid, busy);
        end
        // abort beats start in the same cycle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_over_start: got busy=%b exp 0", busy);
        end
        $display("abort: checked");
        do_measure(3, 1, 50, 1'b1, "post_abort");
        do_ack("post_abort");
    endtask

    task automatic test_back_to_back();
        do_measure(2, 3, 0, 1'b1, "b2b_first");
        result_ack = 1'b1;
        start = 1'b1;
        win_log2 = 5'd1;
        tick();
        result_ack = 1'b0;
        start = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got v=%b b=%b exp v=0 b=1", result_valid, busy);
        end
        do_measure(1, 1, 40, 1'b0, "b2b_second");
        do_ack("b2b_second");
    endtask

    task automatic test_clamp();
        do_measure(20, 0, 63, 1'b1, "clamp_w20");
        checks++;
        if (ratio_q !== 22'h3F0000) begin
            errors++;
            $display("FAIL clamp_abs: got %h exp 3f0000", ratio_q);
        end
        do_ack("clamp_w20");
    endtask

    task automatic test_async_reset();
        win_log2 = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8 + 3) begin
            div_ctrl = 6'($urandom_range(0, 63));
            tick();
        end
        #2;
        rstn_clkin_s = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || ratio_q !== 22'd0 ||
            ctrl_min !== 6'd0 || ctrl_max !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got b=%b v=%b ratio=%h min=%0d max=%0d exp all 0",
                     busy, result_valid, ratio_q, ctrl_min, ctrl_max);
        end
        @(negedge div_clk_out);
        rstn_clkin_s = 1'b1;
        repeat (30) tick();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got b=%b v=%b exp 0 0", busy, result_valid);
        end
        $display("async reset: checked");
        do_measure(2, 3, 0, 1'b1, "post_reset");
        do_ack("post_reset");
    endtask

    initial begin
        test_reset();
        test_constant();
        test_alternating();
        test_mash_hold();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
